ab_pair_collector: RTL and testbench



---
 rtl/ab_pkg.sv | 30 +++
 rtl/ab_pair_collector_if.sv | 43 ++++
 rtl/ab_fifo_mem.sv | 81 ++++++++
 rtl/ab_pair_collector.sv | 108 ++++++++++
 tb/tb_ab_pair_collector.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ab_pkg.sv
// ---------------------------------------------------------------------------
// ab_pkg
// Shared defaults and entry layout for the a/b pair collector.
//   DATA_W_DEF / DEPTH_DEF / CNT_W_DEF : default parameter values
//   pair_t  : {a, b} byte pair, a in the MSBs
//   entry_t : one FIFO entry, {pair, mismatch flag}
//   entry_w : flat width of an entry for a given lane width
// ---------------------------------------------------------------------------
package ab_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int CNT_W_DEF  = 16;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] a;
        logic [DATA_W_DEF-1:0] b;
    } pair_t;

    typedef struct packed {
        pair_t pair;
        logic  mm;
    } entry_t;

    // Entries are stored flat as {a, b, mm} so the FIFO width follows DATA_W.
    function automatic int entry_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/ab_pair_collector_if.sv
// ---------------------------------------------------------------------------
// ab_pair_collector_if
// Sample input, flush and output stream of the pair collector.
//   i_en/i_a/i_b : sample strobe and lane values
//   i_flush      : clear FIFO and duplicate history
//   i_ready      : downstream takes the head this cycle
//   o_valid/o_data/o_mismatch : head of the FIFO (first-word-fall-through)
//   o_full/o_level/o_drop_cnt : occupancy and saturating drop count
// Modports: master drives the inputs (producer/consumer side), slave is the
// collector itself.
// ---------------------------------------------------------------------------
interface ab_pair_collector_if
    import ab_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                  i_en;
    logic [DATA_W-1:0]     i_a;
    logic [DATA_W-1:0]     i_b;
    logic                  i_flush;
    logic                  i_ready;
    logic                  o_valid;
    logic [2*DATA_W-1:0]   o_data;
    logic                  o_mismatch;
    logic                  o_full;
    logic [LVL_W-1:0]      o_level;
    logic [CNT_W-1:0]      o_drop_cnt;

    modport master (
        output i_en, i_a, i_b, i_flush, i_ready,
        input  o_valid, o_data, o_mismatch, o_full, o_level, o_drop_cnt
    );

    modport slave (
        input  i_en, i_a, i_b, i_flush, i_ready,
        output o_valid, o_data, o_mismatch, o_full, o_level, o_drop_cnt
    );

endinterface

// File: rtl/ab_fifo_mem.sv
// ---------------------------------------------------------------------------
// ab_fifo_mem
// First-word-fall-through FIFO storage with pointers and occupancy.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_flush      : empty the FIFO (contents kept, pointers/level cleared)
//   i_push/i_wdata : write one entry at the tail
//   i_pop        : advance the head
//   o_rdata      : entry at the read pointer (valid when o_empty=0)
//   o_level/o_full/o_empty : occupancy status
// The caller guarantees push only when not full or when popping.
// ---------------------------------------------------------------------------
module ab_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_wdata,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q] = i_wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (i_pop && !i_push) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    // Storage is cleared on reset so the empty head reads as zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_level = level_q;
    assign o_full  = (level_q == LVL_W'(DEPTH));
    assign o_empty = (level_q == '0);

endmodule

// File: rtl/ab_pair_collector.sv
// ---------------------------------------------------------------------------
// ab_pair_collector
// Samples {a,b} byte pairs, suppresses consecutive duplicates, buffers
// accepted pairs in a small FIFO and presents them on a valid/ready stream
// with a capture-time a!=b flag. Offers lost to a full FIFO are counted.
//   i_clk, i_rst : clock, synchronous active-high reset (beats flush)
//   bus          : ab_pair_collector_if slave (sample in, stream out, status)
// ---------------------------------------------------------------------------
module ab_pair_collector
    import ab_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ab_pair_collector_if.slave    bus
);
    localparam int EW    = entry_w(DATA_W);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [2*DATA_W-1:0] cand;
    logic [2*DATA_W-1:0] last_q, last_d;
    logic                last_vld_q, last_vld_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic                dup;
    logic                offer_new;
    logic                push;
    logic                pop;
    logic                drop;

    logic [EW-1:0]       wr_entry;
    logic [EW-1:0]       rd_entry;
    logic [LVL_W-1:0]    level;
    logic                full;
    logic                empty;

    assign cand     = {bus.i_a, bus.i_b};
    assign wr_entry = {cand, (bus.i_a != bus.i_b)};

    always_comb begin
        pop        = 1'b0;
        dup        = 1'b0;
        offer_new  = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        drop_cnt_d = drop_cnt_q;

        pop       = !empty && bus.i_ready && !bus.i_flush;
        dup       = last_vld_q && (cand == last_q);
        offer_new = bus.i_en && !dup && !bus.i_flush;
        // A full FIFO still accepts when the head leaves on the same edge.
        push      = offer_new && (!full || pop);
        drop      = offer_new && full && !pop;

        if (bus.i_flush) begin
            last_vld_d = 1'b0;
        end else if (push) begin
            last_d     = cand;
            last_vld_d = 1'b1;
        end

        // History is left alone on a drop so the same pair is retried.
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    ab_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (bus.i_flush),
        .i_push  (push),
        .i_wdata (wr_entry),
        .i_pop   (pop),
        .o_rdata (rd_entry),
        .o_level (level),
        .o_full  (full),
        .o_empty (empty)
    );

    assign bus.o_valid    = !empty;
    assign bus.o_data     = rd_entry[EW-1:1];
    assign bus.o_mismatch = rd_entry[0];
    assign bus.o_full     = full;
    assign bus.o_level    = level;
    assign bus.o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ab_pair_collector.sv
// ---------------------------------------------------------------------------
// tb_ab_pair_collector
// Directed vector table, randomized run against a queue-based reference
// model, and a narrow-counter instance for drop-count saturation and reset.
// ---------------------------------------------------------------------------
module tb_ab_pair_collector;
    import ab_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1;
    logic rst2;

    ab_pair_collector_if #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) bus1 ();
    ab_pair_collector_if #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(2))  bus2 ();

    ab_pair_collector #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut1 (
        .i_clk (clk),
        .i_rst (rst1),
        .bus   (bus1)
    );

    ab_pair_collector #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .i_clk (clk),
        .i_rst (rst2),
        .bus   (bus2)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        en;
        logic        ready;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_data;
        logic        exp_mm;
        int          exp_level;
        int          exp_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic flush, input logic en, input logic ready,
                       input logic [7:0] a, input logic [7:0] b, input logic [15:0] ed,
                       input logic em, input int el, input int edrop);
        vec_t v;
        v.rst = rst; v.flush = flush; v.en = en; v.ready = ready;
        v.a = a; v.b = b; v.exp_data = ed; v.exp_mm = em;
        v.exp_level = el; v.exp_drop = edrop;
        vecs.push_back(v);
    endtask

    task automatic drive1(input logic rst, input logic flush, input logic en, input logic ready,
                          input logic [7:0] a, input logic [7:0] b);
        rst1         = rst;
        bus1.i_flush = flush;
        bus1.i_en    = en;
        bus1.i_ready = ready;
        bus1.i_a     = a;
        bus1.i_b     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic rst, input logic en, input logic [7:0] a, input logic [7:0] b);
        rst2         = rst;
        bus2.i_flush = 1'b0;
        bus2.i_en    = en;
        bus2.i_ready = 1'b0;
        bus2.i_a     = a;
        bus2.i_b     = b;
        @(posedge clk);
        #1;
    endtask

    // Check dut1 outputs against a full expectation; data/mm only when a head
    // exists or right after reset (when the read slot is known to be zero).
    task automatic check1(input string tag, input logic [15:0] ed, input logic em,
                          input int el, input int edrop, input logic chk_data);
        check({tag, ".valid"}, 32'(bus1.o_valid), 32'(el != 0));
        check({tag, ".level"}, 32'(bus1.o_level), 32'(el));
        check({tag, ".full"},  32'(bus1.o_full),  32'(el == DEPTH));
        check({tag, ".drop"},  32'(bus1.o_drop_cnt), 32'(edrop));
        if (chk_data) begin
            check({tag, ".data"}, 32'(bus1.o_data), 32'(ed));
            check({tag, ".mm"},   32'(bus1.o_mismatch), 32'(em));
        end
    endtask

    // Reference model state for the random phase.
    entry_t      mq[$];
    logic [15:0] m_last;
    logic        m_last_vld;
    int          m_drop;

    task automatic model_step(input logic rst, input logic flush, input logic en,
                              input logic ready, input logic [7:0] a, input logic [7:0] b);
        entry_t e;
        logic   popping;
        if (rst) begin
            mq.delete();
            m_last_vld = 1'b0;
            m_last     = '0;
            m_drop     = 0;
        end else if (flush) begin
            mq.delete();
            m_last_vld = 1'b0;
        end else begin
            popping = (mq.size() != 0) && ready;
            if (popping) void'(mq.pop_front());
            if (en && !(m_last_vld && ({a, b} == m_last))) begin
                if (mq.size() < DEPTH) begin
                    e.pair.a = a;
                    e.pair.b = b;
                    e.mm     = (a != b);
                    mq.push_back(e);
                    m_last     = {a, b};
                    m_last_vld = 1'b1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
        end
    endtask

    initial begin
        logic r, f, en, rd;
        logic [7:0] a, b;
        string tag;

        rst1 = 1'b1; rst2 = 1'b1;
        bus1.i_en = 0; bus1.i_a = 0; bus1.i_b = 0; bus1.i_flush = 0; bus1.i_ready = 0;
        bus2.i_en = 0; bus2.i_a = 0; bus2.i_b = 0; bus2.i_flush = 0; bus2.i_ready = 0;

        //   rst flush en rdy  a      b      data      mm lvl drop
        add(1, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 0, 0, 0);
        add(0, 0, 1, 0, 8'h11, 8'h11, 16'h1111, 0, 1, 0);
        add(0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, 0, 0, 0);
        add(0, 0, 1, 0, 8'hA5, 8'h5A, 16'hA55A, 1, 1, 0);
        add(0, 0, 1, 0, 8'hA5, 8'h5A, 16'hA55A, 1, 1, 0);
        add(0, 0, 1, 0, 8'hA5, 8'h5A, 16'hA55A, 1, 1, 0);
        add(0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, 0, 0, 0);
        add(0, 0, 1, 0, 8'h01, 8'h01, 16'h0101, 0, 1, 0);
        add(0, 0, 1, 0, 8'h02, 8'h02, 16'h0101, 0, 2, 0);
        add(0, 0, 1, 0, 8'h03, 8'h03, 16'h0101, 0, 3, 0);
        add(0, 0, 1, 0, 8'h04, 8'h04, 16'h0101, 0, 4, 0);
        add(0, 0, 1, 0, 8'h05, 8'h05, 16'h0101, 0, 4, 1);
        add(0, 0, 1, 0, 8'h06, 8'h06, 16'h0101, 0, 4, 2);
        add(0, 0, 0, 1, 8'h00, 8'h00, 16'h0202, 0, 3, 2);
        add(0, 0, 0, 1, 8'h00, 8'h00, 16'h0303, 0, 2, 2);
        add(0, 0, 0, 1, 8'h00, 8'h00, 16'h0404, 0, 1, 2);
        add(0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, 0, 0, 2);
        add(0, 0, 1, 0, 8'h10, 8'h10, 16'h1010, 0, 1, 2);
        add(0, 0, 1, 0, 8'h20, 8'h20, 16'h1010, 0, 2, 2);
        add(0, 0, 1, 0, 8'h30, 8'h30, 16'h1010, 0, 3, 2);
        add(0, 0, 1, 0, 8'h40, 8'h40, 16'h1010, 0, 4, 2);
        add(0, 0, 1, 1, 8'h77, 8'h00, 16'h2020, 0, 4, 2);
        add(0, 0, 0, 1, 8'h00, 8'h00, 16'h3030, 0, 3, 2);
        add(0, 0, 0, 1, 8'h00, 8'h00, 16'h4040, 0, 2, 2);
        add(0, 0, 0, 1, 8'h00, 8'h00, 16'h7700, 1, 1, 2);
        add(0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, 0, 0, 2);
        add(0, 0, 1, 0, 8'h0A, 8'h0B, 16'h0A0B, 1, 1, 2);
        add(0, 0, 1, 0, 8'h0C, 8'h0D, 16'h0A0B, 1, 2, 2);
        add(0, 0, 1, 0, 8'h01, 8'h02, 16'h0A0B, 1, 3, 2);
        add(0, 1, 1, 1, 8'h01, 8'h02, 16'h0000, 0, 0, 2);
        add(0, 0, 1, 0, 8'h01, 8'h02, 16'h0102, 1, 1, 2);
        add(1, 0, 1, 0, 8'h09, 8'h08, 16'h0000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive1(vecs[i].rst, vecs[i].flush, vecs[i].en, vecs[i].ready, vecs[i].a, vecs[i].b);
            tag = $sformatf("vec%0d", i);
            check1(tag, vecs[i].exp_data, vecs[i].exp_mm, vecs[i].exp_level,
                   vecs[i].exp_drop, (vecs[i].exp_level != 0) || vecs[i].rst);
        end

        // Randomized run; the DUT was just reset by the last vector.
        mq.delete();
        m_last = '0;
        m_last_vld = 1'b0;
        m_drop = 0;
        for (int c = 0; c < 600; c++) begin
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 29) == 0);
            en = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 9) < 4);
            a  = 8'($urandom_range(0, 2));
            b  = 8'($urandom_range(0, 2));
            model_step(r, f, en, rd, a, b);
            drive1(r, f, en, rd, a, b);
            tag = $sformatf("rnd%0d", c);
            if (mq.size() != 0)
                check1(tag, mq[0].pair, mq[0].mm, mq.size(), m_drop, 1'b1);
            else
                check1(tag, 16'h0000, 1'b0, 0, m_drop, r);
        end

        // Narrow drop counter: saturates at 3, then reset clears everything.
        rst1 = 1'b0;
        bus1.i_en = 0;
        drive2(1, 0, 8'h00, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            drive2(0, 1, 8'(i + 1), 8'h00);
        end
        check("sat.level", 32'(bus2.o_level), 32'(DEPTH));
        check("sat.full",  32'(bus2.o_full), 32'd1);
        check("sat.head",  32'(bus2.o_data), 32'h0100);
        check("sat.mm",    32'(bus2.o_mismatch), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            drive2(0, 1, 8'(8'h20 + i), 8'h00);
            check($sformatf("sat.drop%0d", i), 32'(bus2.o_drop_cnt), 32'((i < 3) ? i : 3));
        end
        drive2(1, 1, 8'h55, 8'h66);
        check("rst.valid", 32'(bus2.o_valid), 32'd0);
        check("rst.data",  32'(bus2.o_data), 32'd0);
        check("rst.mm",    32'(bus2.o_mismatch), 32'd0);
        check("rst.full",  32'(bus2.o_full), 32'd0);
        check("rst.level", 32'(bus2.o_level), 32'd0);
        check("rst.drop",  32'(bus2.o_drop_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
